serial_word_packer: RTL and testbench

Collects a stream of received serial bytes into words of BYTES_PER_WORD bytes and writes each word to a video/frame RAM at a sequential address. The block sits between the UART receiver (byte strobe) and the display RAM write port. It adds features the earlier fixed 3-byte assembler does not have:
- parametrised word size, depth and byte order
- write backpressure
- frame wrap detection
- inter-byte timeout resync
- overflow reporting
- a synchronous restart input

---
 rtl/serial_word_packer_pkg.sv | 22 ++
 rtl/inactivity_timer.sv | 33 +++
 rtl/serial_word_packer.sv | 108 ++++++++++
 tb/tb_serial_word_packer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_packer_pkg.sv
// Shared types and sizing helpers for the serial byte-to-word packer.
package serial_word_packer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    WRITE   = 1'b1
  } state_t;

  function automatic int word_width(input int bytes_per_word);
    return 8 * bytes_per_word;
  endfunction

  function automatic int idx_width(input int bytes_per_word);
    return (bytes_per_word <= 2) ? 1 : $clog2(bytes_per_word);
  endfunction

  // Byte lane that the idx-th received byte of a word lands in.
  function automatic int lane_of(input int idx, input int bytes_per_word, input bit lsb_first);
    return lsb_first ? idx : bytes_per_word - 1 - idx;
  endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Counts idle cycles while a partial word is open; pulses expire on the
// TIMEOUT_CYC-th consecutive idle cycle. TIMEOUT_CYC=0 never expires.
module inactivity_timer #(
  parameter int TIMEOUT_CYC = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  // A restart in the would-be expiry cycle wins over the expiry.
  assign expire = (TIMEOUT_CYC > 0) && run && !restart && (count == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator runs the blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (restart || !run || expire) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_word_packer.sv
// Packs received UART bytes into BYTES_PER_WORD-byte words and writes them to
// sequential frame RAM addresses with backpressure, wrap, timeout and restart.
module serial_word_packer
  import serial_word_packer_pkg::*;
#(
  parameter int BYTES_PER_WORD = 3,
  parameter int ADDR_W         = 10,
  parameter int DEPTH          = 1024,
  parameter bit LSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYC    = 0,
  localparam int WW            = word_width(BYTES_PER_WORD),
  localparam int IW            = idx_width(BYTES_PER_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        data_in,
  input  logic              clear,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [WW-1:0]     wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_done,
  output logic              overflow,
  output logic              timeout_err
);

  localparam logic [IW-1:0]     LAST_IDX  = IW'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t        state, state_next;
  logic [IW-1:0] idx;
  logic          accept, capture, last_byte, expire, timer_run, timer_restart;
  int            lane;

  // Decoded from the state flop, so an async reset drops wr_en at once.
  assign wr_en = (state == WRITE);

  // idx is held at 0 throughout WRITE, so a byte arriving with the accept
  // naturally lands as the first byte of the next word.
  // NOTE: every signal driven here gets a default first so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    accept     = wr_en && wr_ready;
    capture    = rx_valid && ((state == COLLECT) || accept);
    last_byte  = (idx == LAST_IDX);
    lane       = lane_of(int'(idx), BYTES_PER_WORD, LSB_FIRST);
    state_next = state;
    case (state)
      COLLECT: if (capture && last_byte) state_next = WRITE;
      WRITE:   if (accept) state_next = (capture && last_byte) ? WRITE : COLLECT;
      default: state_next = COLLECT;
    endcase
    if (clear) state_next = COLLECT;
  end

  assign timer_run     = (state == COLLECT) && (idx != '0);
  assign timer_restart = rx_valid || clear;

  inactivity_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (timer_run),
    .restart(timer_restart),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= COLLECT;
    else        state <= state_next;
  end

  // NOTE: the assembly register is reset like any other flop so wr_data is
  // defined from the first cycle; it is left alone by clear because unwritten
  // lanes only ever matter at accept time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx         <= '0;
      wr_data     <= '0;
      wr_addr     <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else if (clear) begin
      idx         <= '0;
      wr_addr     <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_done  <= accept && (wr_addr == LAST_ADDR);
      timeout_err <= expire;
      if (accept) wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);
      if (rx_valid && wr_en && !wr_ready) overflow <= 1'b1;
      if (capture) begin
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
          if (i == lane) wr_data[8*i +: 8] <= data_in;
        end
        idx <= last_byte ? '0 : idx + IW'(1);
      end else if (expire) begin
        idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_packer.sv
// Scoreboard bench: two packers (LSB-first and MSB-first) share one stimulus
// stream and are checked against a byte-queue reference model.
module tb_serial_word_packer;

  localparam int BPW    = 3;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int TMO    = 8;
  localparam int WW     = 8 * BPW;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        data_in = '0;
  logic              clear = 1'b0;
  logic              wr_ready = 1'b0;
  logic              wr_en_a, wr_en_b, frame_done_a, frame_done_b;
  logic              overflow_a, overflow_b, timeout_err_a, timeout_err_b;
  logic [WW-1:0]     wr_data_a, wr_data_b;
  logic [ADDR_W-1:0] wr_addr_a, wr_addr_b;

  always #5 clk = ~clk;

  serial_word_packer #(
    .BYTES_PER_WORD(BPW), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LSB_FIRST(1'b1), .TIMEOUT_CYC(TMO)
  ) dut_a (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .data_in(data_in), .clear(clear),
    .wr_ready(wr_ready), .wr_en(wr_en_a), .wr_data(wr_data_a), .wr_addr(wr_addr_a),
    .frame_done(frame_done_a), .overflow(overflow_a), .timeout_err(timeout_err_a)
  );

  serial_word_packer #(
    .BYTES_PER_WORD(BPW), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LSB_FIRST(1'b0), .TIMEOUT_CYC(TMO)
  ) dut_b (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .data_in(data_in), .clear(clear),
    .wr_ready(wr_ready), .wr_en(wr_en_b), .wr_data(wr_data_b), .wr_addr(wr_addr_b),
    .frame_done(frame_done_b), .overflow(overflow_b), .timeout_err(timeout_err_b)
  );

  typedef struct {
    logic [WW-1:0] word_lsb;
    logic [WW-1:0] word_msb;
    int            addr;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         fd_count = 0;

  // Reference model state: bytes of the open word, one pending word flag,
  // next write address, idle-cycle count and expected flag outputs.
  logic [7:0] m_bytes[$];
  bit         m_pend, m_fd, m_to, m_ovf;
  int         m_addr, m_idle;

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step();
    exp_t e;
    if (!reset || clear) begin
      m_bytes.delete();
      exp_q.delete();
      m_pend = 0; m_fd = 0; m_to = 0; m_ovf = 0; m_addr = 0; m_idle = 0;
      return;
    end
    m_fd = 0;
    m_to = 0;
    if (m_pend && wr_ready) begin
      m_pend = 0;
      m_fd   = (m_addr == DEPTH - 1);
      m_addr = (m_addr + 1) % DEPTH;
    end
    if (rx_valid) begin
      if (m_pend) begin
        m_ovf = 1;
      end else begin
        m_bytes.push_back(data_in);
        m_idle = 0;
        if (m_bytes.size() == BPW) begin
          e.word_lsb = '0;
          e.word_msb = '0;
          for (int i = 0; i < BPW; i++) begin
            e.word_lsb = e.word_lsb | (WW'(m_bytes[i]) << (8 * i));
            e.word_msb = e.word_msb | (WW'(m_bytes[i]) << (8 * (BPW - 1 - i)));
          end
          e.addr = m_addr;
          exp_q.push_back(e);
          m_pend = 1;
          m_bytes.delete();
        end
      end
    end else if (!m_pend && m_bytes.size() != 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_bytes.delete();
        m_idle = 0;
        m_to   = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      model_step();
    end
  end

  // Monitor: flags every cycle, write contents whenever the RAM accepts.
  initial begin
    forever begin
      @(negedge clk);
      check("wr_en_a", wr_en_a, m_pend);
      check("wr_en_b", wr_en_b, m_pend);
      check("wr_addr_a", wr_addr_a, m_addr);
      check("wr_addr_b", wr_addr_b, m_addr);
      check("frame_done", {frame_done_a, frame_done_b}, {m_fd, m_fd});
      check("overflow", {overflow_a, overflow_b}, {m_ovf, m_ovf});
      check("timeout_err", {timeout_err_a, timeout_err_b}, {m_to, m_to});
      if (frame_done_a) fd_count++;
      if ((wr_en_a || wr_en_b) && wr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          check("write_data_a", wr_data_a, exp_q[0].word_lsb);
          check("write_data_b", wr_data_b, exp_q[0].word_msb);
          check("write_addr", wr_addr_a, exp_q[0].addr);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive(bit v, logic [7:0] d, bit rdy, bit clr);
    @(posedge clk);
    #1;
    rx_valid = v;
    data_in  = d;
    wr_ready = rdy;
    clear    = clr;
  endtask

  task automatic idle(int n, bit rdy);
    repeat (n) drive(1'b0, 8'h00, rdy, 1'b0);
  endtask

  initial begin
    int probs[3] = '{8, 45, 90};

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_a", {wr_en_a, wr_data_a, wr_addr_a, frame_done_a, overflow_a, timeout_err_a}, 0);
    check("reset_outputs_b", {wr_en_b, wr_data_b, wr_addr_b, frame_done_b, overflow_b, timeout_err_b}, 0);
    reset = 1'b1;

    // First word: byte order and one-cycle write at address 0.
    drive(1, 8'h11, 1, 0);
    drive(1, 8'h22, 1, 0);
    drive(1, 8'h33, 1, 0);
    drive(0, 8'h00, 1, 0);
    @(negedge clk);
    check("basic_wr_en", wr_en_a, 1);
    check("basic_lsb_first", wr_data_a, 24'h332211);
    check("basic_msb_first", wr_data_b, 24'h112233);
    check("basic_addr", wr_addr_a, 0);
    drive(0, 8'h00, 1, 0);
    @(negedge clk);
    check("basic_next_addr", wr_addr_a, 1);
    check("basic_wr_en_drop", wr_en_a, 0);

    // Full frame: 8 words back to back, one frame_done, address wraps.
    drive(0, 8'h00, 1, 1);
    fd_count = 0;
    for (int i = 0; i < 3 * DEPTH; i++) drive(1, 8'(i * 7 + 3), 1, 0);
    idle(3, 1);
    @(negedge clk);
    check("frame_done_count", fd_count, 1);
    check("wrap_addr", wr_addr_a, 0);

    // Backpressure: byte 0x44 dropped during stall, 0x55 taken with the accept.
    drive(1, 8'hA1, 1, 0);
    drive(1, 8'hA2, 1, 0);
    drive(1, 8'hA3, 0, 0);
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0);
    drive(1, 8'h44, 0, 0);
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0);
    @(negedge clk);
    check("stall_wr_en", wr_en_a, 1);
    check("stall_data_held", wr_data_a, 24'hA3A2A1);
    check("stall_overflow", overflow_a, 1);
    drive(1, 8'h55, 1, 0);
    drive(1, 8'h66, 1, 0);
    drive(1, 8'h77, 1, 0);
    drive(0, 8'h00, 1, 0);
    @(negedge clk);
    check("after_stall_word", wr_data_a, 24'h776655);
    check("after_stall_addr", wr_addr_a, 1);

    // Inter-byte timeout discards 0xAA,0xBB; next word lands at address 2.
    drive(1, 8'hAA, 1, 0);
    drive(1, 8'hBB, 1, 0);
    idle(TMO, 1);
    drive(0, 8'h00, 1, 0);
    @(negedge clk);
    check("timeout_pulse", timeout_err_a, 1);
    check("timeout_no_write", wr_en_a, 0);
    drive(1, 8'h01, 1, 0);
    drive(1, 8'h02, 1, 0);
    drive(1, 8'h03, 1, 0);
    drive(0, 8'h00, 1, 0);
    @(negedge clk);
    check("post_timeout_lsb", wr_data_a, 24'h030201);
    check("post_timeout_msb", wr_data_b, 24'h010203);
    check("post_timeout_addr", wr_addr_a, 2);

    // Two more words bring the address to 5, then clear mid-word.
    for (int i = 0; i < 8; i++) drive(1, 8'(8'hC0 + i), 1, 0);
    @(negedge clk);
    check("pre_clear_addr", wr_addr_a, 5);
    check("pre_clear_overflow", overflow_a, 1);
    drive(0, 8'h00, 1, 1);
    drive(0, 8'h00, 1, 0);
    @(negedge clk);
    check("clear_addr", wr_addr_a, 0);
    check("clear_overflow", overflow_a, 0);
    check("clear_wr_en", wr_en_a, 0);

    // Async reset in the middle of a stalled write.
    drive(1, 8'hD1, 0, 0);
    drive(1, 8'hD2, 0, 0);
    drive(1, 8'hD3, 0, 0);
    drive(0, 8'h00, 0, 0);
    @(negedge clk);
    check("pre_reset_wr_en", wr_en_a, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_a", {wr_en_a, wr_data_a, wr_addr_a, frame_done_a, overflow_a, timeout_err_a}, 0);
    check("async_reset_b", {wr_en_b, wr_data_b, wr_addr_b, frame_done_b, overflow_b, timeout_err_b}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Randomised traffic with varying byte density, stalls and rare clears.
    for (int blk = 0; blk < 12; blk++) begin
      int p;
      p = probs[blk % 3];
      repeat (200) begin
        drive($urandom_range(99) < p, 8'($urandom), $urandom_range(99) < 70,
              $urandom_range(299) == 0);
      end
    end

    idle(5, 1);
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
